uart_tx_frame: RTL and testbench

Serial transmitter that is the send-side counterpart of the serial receive path. It accepts a parallel byte with a one-cycle start strobe and shifts it out LSB-first on a single line as a framed character: start bit, data bits, optional parity bit, then stop bit. Each bit is held for a programmable number of clock cycles. The block sits between the host-side register interface and the off-chip serial line. Its frame format (5, 7 or 8 data bits, one start bit, one stop bit, no parity by default) matches the receiver's expectations exactly.

---
 rtl/uart_tx_frame.sv | 143 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, LSB-first data (5/7/8 bits), optional even parity, stop bit.
// Define UART_TX_PARITY_EN to compile in the even-parity bit after the data bits.
module uart_tx_frame (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] bit_period,
    input  logic [3:0]  data_size,
    input  logic [7:0]  tx_data,
    input  logic        tx_start,
    output logic        tx_ready,
    output logic        tx_done,
    output logic        serial_out
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state;
    logic [13:0] cnt;
    logic [3:0]  bit_idx;
    logic [7:0]  shreg;
    logic [3:0]  n_bits;
    logic [13:0] period;
`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    logic [3:0]  size_n;
    logic [7:0]  size_mask;
    logic [13:0] period_eff;
    logic        last_cycle;

    always_comb begin
        size_n    = 4'd5;
        size_mask = 8'h1F;
        if (data_size == 4'd8) begin
            size_n    = 4'd8;
            size_mask = 8'hFF;
        end else if (data_size == 4'd7) begin
            size_n    = 4'd7;
            size_mask = 8'h7F;
        end
        period_eff = (bit_period < 14'd2) ? 14'd2 : bit_period;
        // cnt runs 0..P-1 while the bit is held; the last value ends the bit
        last_cycle = (cnt == period - 14'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            n_bits     <= 4'd5;
            period     <= 14'd2;
            serial_out <= 1'b1;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shreg      <= tx_data & size_mask;
                        n_bits     <= size_n;
                        period     <= period_eff;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^(tx_data & size_mask);
`endif
                        cnt        <= '0;
                        bit_idx    <= '0;
                        serial_out <= 1'b0;
                        tx_ready   <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (last_cycle) begin
                        cnt        <= '0;
                        serial_out <= shreg[0];
                        state      <= DATA;
                    end else begin
                        cnt <= cnt + 14'd1;
                    end
                end
                DATA: begin
                    if (last_cycle) begin
                        cnt   <= '0;
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == n_bits - 4'd1) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            serial_out <= parity_bit;
                            state      <= PARITY;
`else
                            serial_out <= 1'b1;
                            state      <= STOP;
`endif
                        end else begin
                            bit_idx    <= bit_idx + 4'd1;
                            serial_out <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 14'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (last_cycle) begin
                        cnt        <= '0;
                        serial_out <= 1'b1;
                        state      <= STOP;
                    end else begin
                        cnt <= cnt + 14'd1;
                    end
                end
`endif
                STOP: begin
                    if (last_cycle) begin
                        cnt      <= '0;
                        tx_ready <= 1'b1;
                        tx_done  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 14'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= 1'b1;
                    tx_ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: per-cycle queue-based frame model plus directed literal checks.
// Honors UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_frame;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] bit_period = 14'd10;
    logic [3:0]  data_size = 4'd8;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_start = 1'b0;
    logic        tx_ready;
    logic        tx_done;
    logic        serial_out;

`ifdef UART_TX_PARITY_EN
    localparam int NEXTRA = 1;
`else
    localparam int NEXTRA = 0;
`endif

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    uart_tx_frame dut (
        .clk(clk),
        .rst(rst),
        .bit_period(bit_period),
        .data_size(data_size),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_ready(tx_ready),
        .tx_done(tx_done),
        .serial_out(serial_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: on acceptance the whole frame is expanded into one line level per cycle.
    bit  q[$];
    bit  m_serial = 1'b1;
    bit  m_ready = 1'b1;
    bit  m_done = 1'b0;
    int  m_n, m_p;
    bit  m_par;
    logic [7:0] m_d;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_serial = 1'b1;
            m_ready  = 1'b1;
            m_done   = 1'b0;
        end else if (m_ready && tx_start) begin
            m_n = (data_size == 4'd8) ? 8 : (data_size == 4'd7) ? 7 : 5;
            m_p = (bit_period < 14'd2) ? 2 : int'(bit_period);
            m_d = tx_data;
            m_par = 1'b0;
            repeat (m_p) q.push_back(1'b0);
            for (int i = 0; i < m_n; i++) begin
                m_par ^= m_d[i];
                repeat (m_p) q.push_back(m_d[i]);
            end
            if (NEXTRA == 1) repeat (m_p) q.push_back(m_par);
            repeat (m_p) q.push_back(1'b1);
            m_serial = q.pop_front();
            m_ready  = 1'b0;
            m_done   = 1'b0;
        end else if (q.size() != 0) begin
            m_serial = q.pop_front();
            m_done   = 1'b0;
        end else if (!m_ready) begin
            m_serial = 1'b1;
            m_ready  = 1'b1;
            m_done   = 1'b1;
        end else begin
            m_serial = 1'b1;
            m_done   = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_bit("model_serial_out", serial_out, m_serial);
            check_bit("model_tx_ready", tx_ready, m_ready);
            check_bit("model_tx_done", tx_done, m_done);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 500 && tx_ready !== 1'b1; i++) @(negedge clk);
        if (tx_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL wait_ready t=%0t actual=%b required=1", $time, tx_ready);
        end
    endtask

    // Returns on the cycle-1 negedge, i.e. the first cycle after the accepting edge.
    task automatic send(input logic [7:0] d, input logic [3:0] s, input logic [13:0] p);
        wait_ready();
        tx_data = d;
        data_size = s;
        bit_period = p;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic run_to_done(input int from, output int n);
        n = from;
        while (tx_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    int a5_bits[9] = '{0, 1, 0, 1, 0, 0, 1, 0, 1};
    int n;

    initial begin
        cyc(2);
        rst = 1'b0;
        chk_en = 1'b1;
        check_bit("reset_serial", serial_out, 1'b1);
        check_bit("reset_ready", tx_ready, 1'b1);
        check_bit("reset_done", tx_done, 1'b0);
        cyc(50);

        // 8-bit frame 0xA5, P=10
        send(8'hA5, 4'd8, 14'd10);
        for (int b = 0; b < 9; b++) begin
            cyc(4);
            check_bit($sformatf("a5_bit%0d", b), serial_out, a5_bits[b][0]);
            cyc(6);
        end
        cyc((10 + NEXTRA) * 10 - 91);
        check_bit("a5_busy_last", tx_ready, 1'b0);
        cyc(1);
        check_bit("a5_ready", tx_ready, 1'b1);
        check_bit("a5_done", tx_done, 1'b1);
        cyc(1);
        check_bit("a5_done_pulse", tx_done, 1'b0);

        // size decode
        send(8'hFF, 4'd7, 14'd4);
        run_to_done(1, n);
        check_int("size7_len", n, 37 + 4 * NEXTRA);
        cyc(3);
        send(8'hFF, 4'd3, 14'd4);
        run_to_done(1, n);
        check_int("size3_len", n, 29 + 4 * NEXTRA);

        // busy strobe ignored, inputs changed mid-frame
        send(8'h3C, 4'd8, 14'd5);
        cyc(11);
        tx_start = 1'b1;
        tx_data = 8'hFF;
        data_size = 4'd5;
        bit_period = 14'd2;
        cyc(1);
        tx_start = 1'b0;
        run_to_done(13, n);
        check_int("busy_len", n, 51 + 5 * NEXTRA);

        // back-to-back on the tx_done cycle
        tx_data = 8'h00;
        data_size = 4'd8;
        bit_period = 14'd3;
        tx_start = 1'b1;
        cyc(1);
        tx_start = 1'b0;
        check_bit("b2b_start", serial_out, 1'b0);
        check_bit("b2b_busy", tx_ready, 1'b0);
        run_to_done(1, n);
        check_int("b2b_len", n, 31 + 3 * NEXTRA);

        // reset during data bit 3
        send(8'hA5, 4'd8, 14'd10);
        cyc(44);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_bit("midrst_serial", serial_out, 1'b1);
        check_bit("midrst_ready", tx_ready, 1'b1);
        check_bit("midrst_done", tx_done, 1'b0);
        cyc(150);
        send(8'h5A, 4'd7, 14'd3);
        run_to_done(1, n);
        check_int("postrst_len", n, 28 + 3 * NEXTRA);

        // reset and strobe in the same cycle
        wait_ready();
        rst = 1'b1;
        tx_start = 1'b1;
        cyc(1);
        rst = 1'b0;
        tx_start = 1'b0;
        check_bit("rst_start_ready", tx_ready, 1'b1);
        check_bit("rst_start_serial", serial_out, 1'b1);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 4'd8, 14'd2);
        cyc(18);
        check_bit("parity_07", serial_out, 1'b1);
        run_to_done(19, n);
        check_int("parity_len", n, 23);
        send(8'h03, 4'd8, 14'd2);
        cyc(18);
        check_bit("parity_03", serial_out, 1'b0);
`endif

        // randomized phase: every input changes freely, model tracks acceptance
        for (int i = 0; i < 3000; i++) begin
            tx_start = ($urandom_range(0, 3) == 0);
            tx_data = 8'($urandom);
            data_size = ($urandom_range(0, 1) == 0) ? 4'(7 + $urandom_range(0, 1)) : 4'($urandom);
            bit_period = 14'($urandom_range(0, 6));
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        tx_start = 1'b0;
        rst = 1'b0;
        cyc(120);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
